y86_wb_regfile: RTL and testbench
=================================

# y86_wb_regfile

Parametrised Y86-64 write-back stage merged with the architectural register file. It accepts one decoded instruction result per cycle through a valid/ready handshake and derives the destinations `dstE` and `dstM` from `icode`, `ifun` and `cnd`. Each result is held for one cycle in a pending stage, then committed to the register file. Two combinational read ports see pending results through a bypass path. The block replaces the flat 15-register pass-through write-back and sits between the memory stage and decode.

## Interface
- `DATA_W`, 64: register width in bits.
- `NREGS`, 15: number of architectural registers; valid indices are 0..NREGS-1.
- `RSP_IDX`, 4: index of the stack pointer.
- `RSP_INIT`, 0: reset value of the stack-pointer register.
- `CNT_W`, 32: width of the retire counter.
- `clk`  in  1  clock. One clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `wb_valid`  in  1  an instruction result is presented.
- `wb_ready`  out  1  the block accepts a result this cycle.
- `icode`, `ifun`  in  4 each  instruction code and function code.
- `cnd`  in  1  condition outcome, used by cmovXX.
- `rA`, `rB`  in  4 each  register specifiers; 4'hF means none.
- `valE`, `valM`  in  DATA_W each  ALU result and memory result.
- `srcA`, `srcB`  in  4 each  read addresses.
- `rd_valA`, `rd_valB`  out  DATA_W each  read data (combinational).
- `halted`  out  1  a halt instruction has been accepted.
- `retired`  out  CNT_W  count of committed instructions.

## Operation
- Destination decode, applied at acceptance:
  - OPq (6) and irmovq (3): `dstE` = rB.
  - cmovXX (2): `dstE` = rB if `cnd`, otherwise none.
  - call (8), ret (9), pushq (A) and popq (B): `dstE` = RSP_IDX.
  - mrmovq (5) and popq (B): `dstM` = rA.
  - All other icodes: both destinations are none.
- Acceptance occurs when `wb_valid && wb_ready` at a rising edge. The decoded `dstE`, `dstM`, `valE` and `valM` are latched into the pending stage, and `pend_v` is set to 1.
- Commit happens on every edge where `pend_v` = 1:
  - `valE` is written to `dstE` and `valM` is written to `dstM`.
  - If `dstE` == `dstM` (popq %rsp), the `valM` write wins.
  - `retired` increments by 1 and wraps modulo 2^CNT_W.
  - `pend_v` reloads from the acceptance condition on the same edge.
- Writes to a destination of 4'hF, or to any index ≥ NREGS, are dropped. The instruction still retires.
- Read port priority, evaluated for each port independently:
  1. Address 4'hF or any index ≥ NREGS returns 0.
  2. Otherwise, a pending `dstM` match returns pending `valM`.
  3. Otherwise, a pending `dstE` match returns pending `valE`.
  4. Otherwise, the register-file value is returned.
- `wb_ready` = !`halted`.
- Accepting icode 0 (halt) sets `halted` on the acceptance edge. The halt instruction itself retires on the next edge. No further results are accepted until `rst`.
- Reset values:
  - Every register is 0, except register RSP_IDX, which is RSP_INIT.
  - `pend_v` = 0, `halted` = 0, `retired` = 0, `wb_ready` = 1.
- Asserting `rst` mid-operation discards any pending write immediately. The register file returns to its reset values.

## Timing
- Write latency is 2 edges: the acceptance edge, then the commit edge. Throughput is 1 result per cycle with no bubbles.
- Bypass: a read issued in the cycle after acceptance returns the new value. From the commit edge onward, the value comes from the register file.
- Back-to-back writes to the same register: the later result overwrites at its own commit edge. The bypass always reflects the youngest pending value.
- When `wb_valid` = 0, `pend_v` clears at the next edge. Nothing is written and `retired` does not increment.
- `rd_valA` and `rd_valB` have zero latency and are purely combinational from `srcA`, `srcB` and the state.

## Test plan
- Reset: assert `rst` asynchronously with no clock edge, using RSP_INIT = 64'h100.
  - Required: `rd_valA` with `srcA` = 4 reads 64'h100.
  - Required: `srcA` = 3 reads 0; `retired` = 0; `wb_ready` = 1.
- OPq: accept icode 6, rB = 9, valE = 50.
  - Required: one cycle later, `srcA` = 9 reads 50 via the bypass.
  - Required: after the commit edge, `srcA` = 9 still reads 50 from the file; `retired` = 1.
- cmov: accept icode 2, rB = 10, valE = 51, `cnd` = 0.
  - Required: r10 unchanged.
  - Repeat with `cnd` = 1. Required: r10 = 51.
- popq %rsp: accept icode B, rA = 4, valE = 0x108, valM = 0x200.
  - Required: r4 = 0x200 after commit.
  - Required: the bypass reads 0x200 in the pending cycle.
- Back-to-back: accept irmovq r2 ← 57, then mrmovq r2 ← 49 on consecutive edges.
  - Required: `srcB` = 2 reads 57, then 49, then 49.
  - Required: `retired` advances by 2.
- Halt plus reset mid-stream: accept icode 0.
  - Required: `wb_ready` = 0 the next cycle; further `wb_valid` pulses are ignored; `retired` increments by 1 only.
  - Assert `rst` while an OPq result is pending. Required: no write lands; `halted` = 0.

Source files
------------

// File: rtl/y86_wb_regfile_if.sv
// Write-back result bus: one decoded Y86-64 instruction result per cycle,
// qualified by a valid/ready handshake.
interface y86_wb_regfile_if #(
  parameter int DATA_W = 64
);
  logic              wb_valid;
  logic              wb_ready;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic              cnd;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valM;

  modport master (
    output wb_valid, icode, ifun, cnd, rA, rB, valE, valM,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, icode, ifun, cnd, rA, rB, valE, valM,
    output wb_ready
  );
endinterface

// File: rtl/y86_wb_regfile.sv
// Y86-64 write-back stage merged with the architectural register file.
// Accepted results sit one cycle in a pending stage (visible through the
// read-port bypass) and are committed to the file on the following edge.
module y86_wb_regfile #(
  parameter int                DATA_W   = 64,
  parameter int                NREGS    = 15,
  parameter int                RSP_IDX  = 4,
  parameter logic [DATA_W-1:0] RSP_INIT = '0,
  parameter int                CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  y86_wb_regfile_if.slave     wb,
  input  logic [3:0]          srcA,
  input  logic [3:0]          srcB,
  output logic [DATA_W-1:0]   rd_valA,
  output logic [DATA_W-1:0]   rd_valB,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [3:0] RSP_A   = 4'(RSP_IDX);
  localparam logic [4:0] NREGS_L = 5'(NREGS);
  localparam logic [3:0] R_NONE  = 4'hF;

  logic [DATA_W-1:0] r_regs [NREGS];

  // pending stage (p1): control
  logic              r_pend_v_p1;
  logic              r_halted;
  logic [CNT_W-1:0]  r_retired;
  // pending stage (p1): data
  logic [3:0]        r_dstE_p1;
  logic [3:0]        r_dstM_p1;
  logic [DATA_W-1:0] r_valE_p1;
  logic [DATA_W-1:0] r_valM_p1;

  logic              w_accept;
  logic [3:0]        w_dstE;
  logic [3:0]        w_dstM;
  logic              w_unused;

  assign w_unused    = ^wb.ifun;
  assign w_accept    = wb.wb_valid && !r_halted;
  assign wb.wb_ready = !r_halted;
  assign halted      = r_halted;
  assign retired     = r_retired;

  // Index is a real register: not the "none" code and inside the file.
  function automatic logic idx_ok(input logic [3:0] a);
    return (a != R_NONE) && ({1'b0, a} < NREGS_L);
  endfunction

  // Read with bypass: pending valM beats pending valE beats the file.
  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] a);
    if (!idx_ok(a))                           return '0;
    else if (r_pend_v_p1 && r_dstM_p1 == a)   return r_valM_p1;
    else if (r_pend_v_p1 && r_dstE_p1 == a)   return r_valE_p1;
    else                                      return r_regs[a];
  endfunction

  assign rd_valA = read_port(srcA);
  assign rd_valB = read_port(srcB);

  // Destination decode of the presented instruction.
  always_comb begin
    w_dstE = R_NONE;
    w_dstM = R_NONE;
    case (wb.icode)
      4'h6, 4'h3:       w_dstE = wb.rB;
      4'h2:             w_dstE = wb.cnd ? wb.rB : R_NONE;
      4'h8, 4'h9, 4'hA: w_dstE = RSP_A;
      4'hB: begin
        w_dstE = RSP_A;
        w_dstM = wb.rA;
      end
      4'h5:             w_dstM = wb.rA;
      default:          ;
    endcase
  end

  // Control: pending flag, halt latch and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_v_p1 <= 1'b0;
      r_halted    <= 1'b0;
      r_retired   <= '0;
    end else begin
      r_pend_v_p1 <= w_accept;
      if (w_accept && wb.icode == 4'h0) r_halted <= 1'b1;
      if (r_pend_v_p1) r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Pending data captured on acceptance.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dstE_p1 <= w_dstE;
      r_dstM_p1 <= w_dstM;
      r_valE_p1 <= wb.valE;
      r_valM_p1 <= wb.valM;
    end
  end

  // Commit of the pending result; the later valM write wins on dstE == dstM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
    end else if (r_pend_v_p1) begin
      if (idx_ok(r_dstE_p1)) r_regs[r_dstE_p1] <= r_valE_p1;
      if (idx_ok(r_dstM_p1)) r_regs[r_dstM_p1] <= r_valM_p1;
    end
  end

endmodule

// File: tb/tb_y86_wb_regfile.sv
// Self-checking bench for y86_wb_regfile: expected bypass/commit values are
// queued when an instruction is driven and popped when the DUT shows them.
module tb_y86_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  srcA = 4'h0;
  logic [3:0]  srcB = 4'h0;
  logic [63:0] rd_valA;
  logic [63:0] rd_valB;
  logic        halted;
  logic [31:0] retired;

  always #5 clk = ~clk;

  y86_wb_regfile_if #(.DATA_W(64)) wb ();

  y86_wb_regfile #(
    .DATA_W   (64),
    .NREGS    (15),
    .RSP_IDX  (4),
    .RSP_INIT (64'h100),
    .CNT_W    (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wb      (wb),
    .srcA    (srcA),
    .srcB    (srcB),
    .rd_valA (rd_valA),
    .rd_valB (rd_valB),
    .halted  (halted),
    .retired (retired)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] sb_q[$];
  int          exp_ret = 0;
  logic [63:0] v;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rdA(input logic [3:0] a, output logic [63:0] val);
    srcA = a;
    #1;
    val = rd_valA;
  endtask

  task automatic rdB(input logic [3:0] a, output logic [63:0] val);
    srcB = a;
    #1;
    val = rd_valB;
  endtask

  task automatic sb_chk(input string tag, input logic [63:0] got);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %h but scoreboard empty", tag, got);
    end else begin
      e = sb_q.pop_front();
      chk(tag, got, e);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm);
    wb.icode    = ic;
    wb.ifun     = 4'h0;
    wb.cnd      = c;
    wb.rA       = ra;
    wb.rB       = rb;
    wb.valE     = ve;
    wb.valM     = vm;
    wb.wb_valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    wb.wb_valid = 1'b0;
    wb.icode = 4'h1; wb.ifun = 4'h0; wb.cnd = 1'b0;
    wb.rA = 4'hF; wb.rB = 4'hF; wb.valE = '0; wb.valM = '0;

    // asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    rdA(4'd4, v); chk("rst_rsp", v, 64'h100);
    rdA(4'd3, v); chk("rst_r3", v, 64'h0);
    chk("rst_retired", retired, 64'd0);
    chk("rst_ready", wb.wb_ready, 64'd1);
    @(posedge clk); #1 rst = 1'b0;

    // OPq r9 <- 50
    drive(4'h6, 1'b0, 4'hF, 4'd9, 64'd50, 64'd0); sb_q.push_back(64'd50);
    step(); wb.wb_valid = 1'b0;
    rdA(4'd9, v); sb_chk("opq_bypass", v);
    step(); exp_ret++;
    rdA(4'd9, v); chk("opq_file", v, 64'd50);
    chk("opq_retired", retired, 64'(exp_ret));

    // cmov not taken: r10 untouched
    drive(4'h2, 1'b0, 4'hF, 4'd10, 64'd51, 64'd0);
    step(); wb.wb_valid = 1'b0;
    rdA(4'd10, v); chk("cmov0_bypass", v, 64'd0);
    step(); exp_ret++;
    rdA(4'd10, v); chk("cmov0_file", v, 64'd0);
    chk("cmov0_retired", retired, 64'(exp_ret));

    // cmov taken
    drive(4'h2, 1'b1, 4'hF, 4'd10, 64'd51, 64'd0); sb_q.push_back(64'd51);
    step(); wb.wb_valid = 1'b0;
    rdA(4'd10, v); sb_chk("cmov1_bypass", v);
    step(); exp_ret++;
    rdA(4'd10, v); chk("cmov1_file", v, 64'd51);

    // popq %rsp: valM wins over valE
    drive(4'hB, 1'b0, 4'd4, 4'hF, 64'h108, 64'h200); sb_q.push_back(64'h200);
    step(); wb.wb_valid = 1'b0;
    rdA(4'd4, v); sb_chk("popq_bypass", v);
    step(); exp_ret++;
    rdA(4'd4, v); chk("popq_file", v, 64'h200);
    chk("popq_retired", retired, 64'(exp_ret));

    // OPq to "none": dropped but retired; address F reads 0
    drive(4'h6, 1'b0, 4'hF, 4'hF, 64'd123, 64'd0);
    step(); wb.wb_valid = 1'b0;
    step(); exp_ret++;
    rdA(4'hF, v); chk("none_rd", v, 64'd0);
    chk("none_retired", retired, 64'(exp_ret));

    // back-to-back irmovq r2 <- 57, mrmovq r2 <- 49
    drive(4'h3, 1'b0, 4'hF, 4'd2, 64'd57, 64'd0); sb_q.push_back(64'd57);
    step();
    rdB(4'd2, v); sb_chk("b2b_first", v);
    drive(4'h5, 1'b0, 4'd2, 4'hF, 64'd0, 64'd49); sb_q.push_back(64'd49);
    step(); wb.wb_valid = 1'b0;
    rdB(4'd2, v); sb_chk("b2b_second", v);
    step(); exp_ret += 2;
    rdB(4'd2, v); chk("b2b_file", v, 64'd49);
    chk("b2b_retired", retired, 64'(exp_ret));

    // halt: further results ignored
    drive(4'h0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
    step();
    chk("halt_ready", wb.wb_ready, 64'd0);
    chk("halt_flag", halted, 64'd1);
    drive(4'h6, 1'b0, 4'hF, 4'd5, 64'd77, 64'd0);
    step(); step(); step();
    wb.wb_valid = 1'b0; exp_ret++;
    chk("halt_retired", retired, 64'(exp_ret));
    rdA(4'd5, v); chk("halt_r5", v, 64'd0);

    // reset pulse to leave halt, then reset while an OPq is pending
    rst = 1'b1; #1 rst = 1'b0;
    chk("rst2_halted", halted, 64'd0);
    drive(4'h6, 1'b0, 4'hF, 4'd7, 64'd99, 64'd0); sb_q.push_back(64'd99);
    step(); wb.wb_valid = 1'b0;
    rdA(4'd7, v); sb_chk("rst_pend_bypass", v);
    rst = 1'b1;
    #1;
    rdA(4'd7, v); chk("rst_discard", v, 64'd0);
    chk("rst_mid_halted", halted, 64'd0);
    chk("rst_mid_retired", retired, 64'd0);
    step(); rst = 1'b0;
    step();
    rdA(4'd7, v); chk("rst_r7_after", v, 64'd0);
    rdA(4'd4, v); chk("rst_rsp_after", v, 64'h100);
    chk("rst_ready_after", wb.wb_ready, 64'd1);
    chk("rst_retired_after", retired, 64'd0);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
